vga_sync_gen: RTL

- Timing generator for the VGA text/graphics path: produces the pixel_x, pixel_y, video_on, hsync and vsync signals that the pixel/graphics generator consumes.
- Runs on the single system clock and uses an internal prescaler to produce a pixel-rate enable, so no derived clock is needed.
- Default timing is 640x480@60 (800x525 total).
- Coordinates are raw counters that start at the sync pulse, so the visible area begins at x=144, y=35.

---
 rtl/vga_pkg.sv | 44 ++++
 rtl/vga_sync_gen_if.sv | 33 +++
 rtl/vga_pix_prescaler.sv | 44 ++++
 rtl/vga_sync_gen.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 constants, derived totals and
// window origins, and the sync polarity encoding. The graphics generator uses
// the same constants for its window bounds, so both blocks agree on where the
// visible area starts.
package vga_pkg;

   // Counter width used for both the horizontal and vertical counters.
   localparam int VGA_CNT_W = 10;

   typedef logic [VGA_CNT_W-1:0] vga_cnt_t;

   // Horizontal timing, in pixels (sync pulse first, then porch/active/porch).
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;

   // Vertical timing, in lines.
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;

   // Derived totals and the first visible coordinate. Counters start at the
   // sync pulse, so the visible window begins at (VGA_HS, VGA_VS).
   localparam int VGA_H_TOTAL = VGA_H_SYNC + VGA_H_BP + VGA_H_ACTIVE + VGA_H_FP;
   localparam int VGA_V_TOTAL = VGA_V_SYNC + VGA_V_BP + VGA_V_ACTIVE + VGA_V_FP;
   localparam int VGA_HS      = VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_VS      = VGA_V_SYNC + VGA_V_BP;

   // Level driven on hsync/vsync while the pulse is asserted.
   typedef enum logic {
      SYNC_ACTIVE_LOW  = 1'b0,
      SYNC_ACTIVE_HIGH = 1'b1
   } sync_pol_e;

   localparam sync_pol_e VGA_SYNC_POL = SYNC_ACTIVE_LOW;

   // Maps "pulse asserted" onto the physical level for a given polarity.
   function automatic logic sync_level(input logic asserted, input logic pol);
      return asserted ? pol : ~pol;
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Bundle between the timing generator and the pixel/graphics generator.
//
// Signalling: there is no valid/ready pair on this bundle. en is a level
// qualifier owned by the consumer side (low freezes all timing). pix_tick and
// frame_start are single-clk strobes from the generator and are 0 whenever en
// is 0. pixel_x, pixel_y, video_on, hsync and vsync are levels that always
// describe the current pixel; a consumer samples them on cycles with
// pix_tick=1 to see each pixel exactly once.
interface vga_sync_gen_if;
   import vga_pkg::*;

   logic     en;
   logic     pix_tick;
   vga_cnt_t pixel_x;
   vga_cnt_t pixel_y;
   logic     video_on;
   logic     hsync;
   logic     vsync;
   logic     frame_start;

   // Timing generator side.
   modport master (
      input  en,
      output pix_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
   );

   // Pixel/graphics generator side.
   modport slave (
      output en,
      input  pix_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
   );

endinterface

// File: rtl/vga_pix_prescaler.sv
// Pixel-rate prescaler: divides the system clock by CLK_DIV to produce a
// pixel-advance strobe for the counters and a registered pix_tick that is
// high on the cycle following each advance. div_cnt holds while i_en is low
// so timing resumes exactly where it stopped.
module vga_pix_prescaler #(
   parameter int CLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_adv,
   output logic o_pix_tick
);

   // A 1-bit counter is kept even for CLK_DIV=1; it simply never leaves 0.
   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_div_cnt;
   logic             r_pix_tick;
   logic             w_wrap;

   // The wrap edge is the edge on which the pixel counters advance.
   assign w_wrap = i_en && (r_div_cnt == DIV_LAST);

   // Divider count and registered tick; both freeze/clear while disabled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div_cnt  <= '0;
         r_pix_tick <= 1'b0;
      end else begin
         r_pix_tick <= w_wrap;
         if (i_en) begin
            r_div_cnt <= w_wrap ? '0 : r_div_cnt + 1'b1;
         end
      end
   end

   assign o_adv = w_wrap;
   // Gate with en so the strobe drops immediately when timing is frozen,
   // rather than one clk later when the register clears.
   assign o_pix_tick = r_pix_tick & i_en;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator. Runs on the system clock with a pixel-rate enable
// from vga_pix_prescaler. h/v counters start at the sync pulse; all outputs
// are registered on the same edge as the counters, so they always describe
// the current (pixel_x, pixel_y) with no extra pipeline stage.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter bit SYNC_POL = bit'(VGA_SYNC_POL)
) (
   input  logic           clk,
   input  logic           rst_n,
   vga_sync_gen_if.master vga
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int HS      = H_SYNC + H_BP;
   localparam int VS      = V_SYNC + V_BP;
   localparam int CNT_MAX = (1 << VGA_CNT_W) - 1;

   // Parameter legality: the divider needs at least one clk per pixel and the
   // totals must fit the 10-bit counters.
   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("vga_sync_gen: CLK_DIV must be at least 1");
   end
   if (H_TOTAL > CNT_MAX) begin : g_bad_h_total
      $error("vga_sync_gen: horizontal total exceeds 10-bit counter range");
   end
   if (V_TOTAL > CNT_MAX) begin : g_bad_v_total
      $error("vga_sync_gen: vertical total exceeds 10-bit counter range");
   end

   // Window bounds as counter-width constants for width-clean compares.
   localparam vga_cnt_t H_LAST   = vga_cnt_t'(H_TOTAL - 1);
   localparam vga_cnt_t V_LAST   = vga_cnt_t'(V_TOTAL - 1);
   localparam vga_cnt_t H_SYNC_C = vga_cnt_t'(H_SYNC);
   localparam vga_cnt_t V_SYNC_C = vga_cnt_t'(V_SYNC);
   localparam vga_cnt_t H_VIS_LO = vga_cnt_t'(HS);
   localparam vga_cnt_t H_VIS_HI = vga_cnt_t'(HS + H_ACTIVE);
   localparam vga_cnt_t V_VIS_LO = vga_cnt_t'(VS);
   localparam vga_cnt_t V_VIS_HI = vga_cnt_t'(VS + V_ACTIVE);

   logic     w_adv;
   logic     w_pix_tick;
   logic     w_h_last;
   logic     w_v_last;
   logic     w_frame_wrap;
   vga_cnt_t w_h_next;
   vga_cnt_t w_v_next;
   logic     w_hsync_next;
   logic     w_vsync_next;
   logic     w_video_next;

   vga_cnt_t r_h_cnt;
   vga_cnt_t r_v_cnt;
   logic     r_hsync;
   logic     r_vsync;
   logic     r_video_on;
   logic     r_frame_start;

   vga_pix_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_en       (vga.en),
      .o_adv      (w_adv),
      .o_pix_tick (w_pix_tick)
   );

   // Next counter values and the decode of those values, so the registered
   // levels line up with the registered counters.
   always_comb begin
      w_h_last     = (r_h_cnt == H_LAST);
      w_v_last     = (r_v_cnt == V_LAST);
      w_frame_wrap = w_h_last && w_v_last;

      w_h_next = w_h_last ? '0 : r_h_cnt + 1'b1;
      w_v_next = r_v_cnt;
      if (w_h_last) begin
         w_v_next = w_v_last ? '0 : r_v_cnt + 1'b1;
      end

      w_hsync_next = sync_level(w_h_next < H_SYNC_C, SYNC_POL);
      w_vsync_next = sync_level(w_v_next < V_SYNC_C, SYNC_POL);
      w_video_next = (w_h_next >= H_VIS_LO) && (w_h_next < H_VIS_HI) &&
                     (w_v_next >= V_VIS_LO) && (w_v_next < V_VIS_HI);
   end

   // Pixel/line counters advance once per pixel and hold while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_adv) begin
         r_h_cnt <= w_h_next;
         r_v_cnt <= w_v_next;
      end
   end

   // Sync and visible-window levels; sync rests deasserted out of reset and
   // only asserts once the first pixel advance has been decoded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hsync    <= ~SYNC_POL;
         r_vsync    <= ~SYNC_POL;
         r_video_on <= 1'b0;
      end else if (w_adv) begin
         r_hsync    <= w_hsync_next;
         r_vsync    <= w_vsync_next;
         r_video_on <= w_video_next;
      end
   end

   // Frame-start strobe: set on the advance that wraps to (0,0), cleared on
   // the next clk (no advance can follow on the very next edge with a wrap).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_adv && w_frame_wrap;
      end
   end

   assign vga.pix_tick    = w_pix_tick;
   assign vga.pixel_x     = r_h_cnt;
   assign vga.pixel_y     = r_v_cnt;
   assign vga.video_on    = r_video_on;
   assign vga.hsync       = r_hsync;
   assign vga.vsync       = r_vsync;
   assign vga.frame_start = r_frame_start & vga.en;

endmodule
